vga_text_render: RTL

Character-cell renderer directly downstream of the VGA timing generator in the VGA console peripheral. It consumes the split pixel/line counters, blank and sync, and fetches character and attribute words from the text buffer one cell ahead of the beam. It looks up 8x12 glyphs in the font ROM, scales them 4x to fill 32x48-pixel cells (32 columns x 16 rows on 1024x768), and drives 2-bit-per-channel RGB plus realigned syncs.

---
 rtl/vga_text_render_if.sv | 20 ++
 rtl/vga_text_render.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_render_if.sv
// Text-buffer and font-ROM access bundle between the character renderer
// (master) and the memories it reads (slave).
interface vga_text_render_if;
  logic        txt_req;
  logic [8:0]  txt_addr;
  logic        txt_ack;
  logic [15:0] txt_data;
  logic [10:0] font_addr;
  logic [7:0]  font_data;

  modport master (
    output txt_req, txt_addr, font_addr,
    input  txt_ack, txt_data, font_data
  );

  modport slave (
    input  txt_req, txt_addr, font_addr,
    output txt_ack, txt_data, font_data
  );
endinterface

// File: rtl/vga_text_render.sv
// Character-cell renderer: fetches the next cell's char/attribute and glyph row
// one cell ahead of the beam, then paints 4x-scaled 8x12 glyphs with IRGB colour.
module vga_text_render #(
  parameter int BLINK_BIT = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         x_hi,
  input  logic [4:0]         x_lo,
  input  logic [4:0]         y_hi,
  input  logic [5:0]         y_lo,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               blank_in,
  vga_text_render_if.master  bus,
  input  logic               cursor_en,
  input  logic [4:0]         cursor_x,
  input  logic [3:0]         cursor_y,
  input  logic               underrun_clr,
  output logic [1:0]         r,
  output logic [1:0]         g,
  output logic [1:0]         b,
  output logic               hsync,
  output logic               vsync,
  output logic               underrun
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_TXT   = 2'd1;
  localparam logic [1:0] ST_FONT  = 2'd2;
  localparam logic [1:0] ST_READY = 2'd3;

  logic [1:0]  state_r;
  logic        txt_req_r;
  logic [8:0]  txt_addr_r;
  logic [10:0] font_addr_r;
  logic [7:0]  next_bits_r;
  logic [3:0]  next_fg_r;
  logic [3:0]  next_bg_r;
  logic        next_inv_r;
  logic [7:0]  cur_bits_r;
  logic [3:0]  cur_fg_r;
  logic [3:0]  cur_bg_r;
  logic [5:0]  frame_cnt_r;
  logic        underrun_r;
  logic [1:0]  r_r;
  logic [1:0]  g_r;
  logic [1:0]  b_r;
  logic        hsync_r;
  logic        vsync_r;

  logic        target_ok_s;
  logic [4:0]  target_col_s;
  logic        trigger_s;
  logic        load_s;
  logic        ack_s;
  logic [2:0]  pix_idx_s;
  logic        cursor_hit_s;
  logic        pix_bit_s;
  logic [3:0]  irgb_s;
  logic        vsync_rise_s;
  logic        unused_bits_s;

  assign unused_bits_s = ^{x_lo[1:0], y_lo[1:0]};

  // Fetch scheduling: which cell comes next, when to start, when to swap in
  always_comb begin
    target_ok_s  = (y_hi < 5'd16) && ((x_hi < 6'd31) || (x_hi == 6'd40));
    target_col_s = (x_hi == 6'd40) ? 5'd0 : (x_hi[4:0] + 5'd1);
    trigger_s    = (x_lo == 5'd0) && target_ok_s && (state_r == ST_IDLE);
    load_s       = ((x_lo == 5'd31) && (x_hi < 6'd31)) ||
                   ((x_hi == 6'd41) && (x_lo == 5'd15));
    ack_s        = (state_r == ST_TXT) && bus.txt_ack && !load_s;
    vsync_rise_s = vsync_in && !vsync_r;
  end

  // Font address is presented in the ack cycle so the ROM word lands in FONT
  assign bus.font_addr = ack_s ? {bus.txt_data[6:0], y_lo[5:2]} : font_addr_r;
  assign bus.txt_req   = txt_req_r;
  assign bus.txt_addr  = txt_addr_r;

  // Glyph pixel selection, cursor overlay and colour pick
  always_comb begin
    pix_idx_s    = 3'd7 - x_lo[4:2];
    cursor_hit_s = cursor_en && frame_cnt_r[BLINK_BIT] &&
                   (x_hi == {1'b0, cursor_x}) && (y_hi == {1'b0, cursor_y}) &&
                   (y_lo[5:2] >= 4'd10);
    pix_bit_s    = cur_bits_r[pix_idx_s] ^ cursor_hit_s;
    if (pix_bit_s) begin
      irgb_s = cur_fg_r;
    end else begin
      irgb_s = cur_bg_r;
    end
  end

  // Fetch FSM; a load event always wins over whatever the FSM is doing
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      txt_req_r   <= 1'b0;
      txt_addr_r  <= 9'd0;
      font_addr_r <= 11'd0;
      next_bits_r <= 8'd0;
      next_fg_r   <= 4'd0;
      next_bg_r   <= 4'd0;
      next_inv_r  <= 1'b0;
      cur_bits_r  <= 8'd0;
      cur_fg_r    <= 4'd0;
      cur_bg_r    <= 4'd0;
    end else if (load_s) begin
      if (state_r == ST_READY) begin
        cur_bits_r <= next_bits_r;
        cur_fg_r   <= next_fg_r;
        cur_bg_r   <= next_bg_r;
      end else begin
        cur_bits_r <= 8'd0;
        cur_fg_r   <= 4'd0;
        cur_bg_r   <= 4'd0;
      end
      state_r   <= ST_IDLE;
      txt_req_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (trigger_s) begin
            state_r    <= ST_TXT;
            txt_req_r  <= 1'b1;
            txt_addr_r <= {y_hi[3:0], target_col_s};
          end
        end
        ST_TXT: begin
          if (bus.txt_ack) begin
            next_fg_r   <= bus.txt_data[11:8];
            next_bg_r   <= bus.txt_data[15:12];
            next_inv_r  <= bus.txt_data[7];
            font_addr_r <= {bus.txt_data[6:0], y_lo[5:2]};
            txt_req_r   <= 1'b0;
            state_r     <= ST_FONT;
          end
        end
        ST_FONT: begin
          next_bits_r <= bus.font_data ^ {8{next_inv_r}};
          state_r     <= ST_READY;
        end
        ST_READY: begin
          state_r <= ST_READY;
        end
        default: begin
          state_r   <= ST_IDLE;
          txt_req_r <= 1'b0;
        end
      endcase
    end
  end

  // Sticky underrun flag; a new miss beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_r <= 1'b0;
    end else if (load_s && (state_r != ST_READY)) begin
      underrun_r <= 1'b1;
    end else if (underrun_clr) begin
      underrun_r <= 1'b0;
    end else begin
      underrun_r <= underrun_r;
    end
  end

  // Frame counter advancing on vsync rising edges, drives the blink phase
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_r <= 6'd0;
    end else if (vsync_rise_s) begin
      frame_cnt_r <= frame_cnt_r + 6'd1;
    end else begin
      frame_cnt_r <= frame_cnt_r;
    end
  end

  // Output stage: one cycle behind the beam, syncs delayed to match
  always_ff @(posedge clk) begin
    if (rst) begin
      r_r     <= 2'd0;
      g_r     <= 2'd0;
      b_r     <= 2'd0;
      hsync_r <= 1'b0;
      vsync_r <= 1'b0;
    end else begin
      hsync_r <= hsync_in;
      vsync_r <= vsync_in;
      if (blank_in) begin
        r_r <= 2'd0;
        g_r <= 2'd0;
        b_r <= 2'd0;
      end else begin
        r_r <= {irgb_s[2], irgb_s[3]};
        g_r <= {irgb_s[1], irgb_s[3]};
        b_r <= {irgb_s[0], irgb_s[3]};
      end
    end
  end

  assign r        = r_r;
  assign g        = g_r;
  assign b        = b_r;
  assign hsync    = hsync_r;
  assign vsync    = vsync_r;
  assign underrun = underrun_r;

endmodule
